// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions for the memory stage: opcodes, funct3 access encodings,
// FSM state type and small access-size helpers.
package riscv_pkg;

    localparam logic [6:0] I_load = 7'd3;
    localparam logic [6:0] I      = 7'd19;
    localparam logic [6:0] U_ADD  = 7'd23;
    localparam logic [6:0] S      = 7'd35;
    localparam logic [6:0] R      = 7'd51;
    localparam logic [6:0] U_LOAD = 7'd55;
    localparam logic [6:0] B      = 7'd99;
    localparam logic [6:0] J      = 7'd111;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {StIdle, StReq, StWait} mem_state_t;
    typedef enum logic [1:0] {SzByte, SzHalf, SzWord} mem_size_t;

    // Undefined funct3 encodings fall through to a full-word access.
    function automatic mem_size_t f3_size(input logic [2:0] f3);
        case (f3)
            F3_B, F3_BU: return SzByte;
            F3_H, F3_HU: return SzHalf;
            default:     return SzWord;
        endcase
    endfunction

    function automatic logic is_misaligned(input mem_size_t sz, input logic [1:0] lo);
        return ((sz == SzHalf) && lo[0]) || ((sz == SzWord) && (lo != 2'b00));
    endfunction

endpackage

// File: rtl/load_align.sv
// Load data lane selection and sign/zero extension from the raw bus word.
module load_align
    import riscv_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_addr_lo,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_lmd
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_rdata[7:0];
        case (i_addr_lo)
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            2'd3:    w_byte = i_rdata[31:24];
            default: w_byte = i_rdata[7:0];
        endcase
        w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

        case (i_funct3)
            F3_B:    o_lmd = {{24{w_byte[7]}}, w_byte};
            F3_BU:   o_lmd = {24'b0, w_byte};
            F3_H:    o_lmd = {{16{w_half[15]}}, w_half};
            F3_HU:   o_lmd = {16'b0, w_half};
            default: o_lmd = i_rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// RISC-V MEM stage: load/store over a req/gnt/rvalid bus, registered WB-side outputs.
// Optional MEM_MISALIGN_TRAP_EN turns misaligned half/word accesses into a trap.
module mem_stage
    import riscv_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              EX_valid,
    input  logic [6:0]        EX_opcode,
    input  logic [2:0]        EX_funct3,
    input  logic [31:0]       EX_ALUout,
    input  logic [31:0]       EX_rs2,
    input  logic [4:0]        ID_rd,
    output logic              MEM_stall,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_wdata,
    output logic [3:0]        dmem_be,
    input  logic              dmem_gnt,
    input  logic              dmem_rvalid,
    input  logic [31:0]       dmem_rdata,
    output logic              MEM_valid,
    output logic [31:0]       MEM_LMD,
    output logic [31:0]       MEM_ALUout,
    output logic [4:0]        MEM_rd,
    output logic              WB_LMD_flag,
    output logic              WB_ALUout_flag,
    output logic              MEM_trap
);

    mem_state_t r_state, w_state_next;

    logic              r_is_load;
    logic [2:0]        r_funct3;
    logic [31:0]       r_alu;
    logic [4:0]        r_rd;
    logic              r_req, r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [3:0]        r_be;
    logic              r_valid, r_lmd_flag, r_alu_flag;
    logic [31:0]       r_lmd, r_alu_out;
    logic [4:0]        r_mem_rd;

    logic        w_accept, w_is_load, w_is_store, w_is_alu, w_misalign, w_go_mem;
    logic        w_done_direct, w_done_store, w_done_load;
    mem_size_t   w_size;
    logic [3:0]  w_be;
    logic [31:0] w_wdata, w_lmd;

    assign w_accept   = (r_state == StIdle) && EX_valid;
    assign w_is_load  = (EX_opcode == I_load);
    assign w_is_store = (EX_opcode == S);
    assign w_is_alu   = (EX_opcode == R) || (EX_opcode == I) ||
                        (EX_opcode == U_ADD) || (EX_opcode == U_LOAD);
    assign w_size     = f3_size(EX_funct3);

`ifdef MEM_MISALIGN_TRAP_EN
    assign w_misalign = (w_is_load || w_is_store) && is_misaligned(w_size, EX_ALUout[1:0]);
`else
    assign w_misalign = 1'b0;
`endif

    assign w_go_mem      = (w_is_load || w_is_store) && !w_misalign;
    assign w_done_direct = w_accept && !w_go_mem;
    assign w_done_store  = (r_state == StReq) && dmem_gnt && !r_is_load;
    assign w_done_load   = (r_state == StWait) && dmem_rvalid;

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = EX_rs2;
        case (w_size)
            SzByte: begin
                w_be    = 4'b0001 << EX_ALUout[1:0];
                w_wdata = {4{EX_rs2[7:0]}};
            end
            SzHalf: begin
                w_be    = 4'b0011 << {EX_ALUout[1], 1'b0};
                w_wdata = {2{EX_rs2[15:0]}};
            end
            default: ;
        endcase
    end

    load_align u_load_align (
        .i_rdata   (dmem_rdata),
        .i_addr_lo (r_alu[1:0]),
        .i_funct3  (r_funct3),
        .o_lmd     (w_lmd)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= StIdle;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle:  if (w_accept && w_go_mem) w_state_next = StReq;
            StReq:   if (dmem_gnt) w_state_next = r_is_load ? StWait : StIdle;
            StWait:  if (dmem_rvalid) w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_is_load  <= 1'b0;
            r_funct3   <= 3'b0;
            r_alu      <= 32'b0;
            r_rd       <= 5'b0;
            r_req      <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= 32'b0;
            r_be       <= 4'b0;
            r_valid    <= 1'b0;
            r_lmd_flag <= 1'b0;
            r_alu_flag <= 1'b0;
            r_lmd      <= 32'b0;
            r_alu_out  <= 32'b0;
            r_mem_rd   <= 5'b0;
        end else begin
            r_valid    <= w_done_direct || w_done_store || w_done_load;
            r_lmd_flag <= w_done_load;
            r_alu_flag <= w_done_direct && w_is_alu;

            if (w_done_direct) begin
                r_alu_out <= EX_ALUout;
                r_mem_rd  <= ID_rd;
            end else if (w_done_store || w_done_load) begin
                r_alu_out <= r_alu;
                r_mem_rd  <= r_rd;
            end
            if (w_done_load) r_lmd <= w_lmd;

            // Bus fields are captured once at accept so they stay stable through REQ.
            if (w_accept && w_go_mem) begin
                r_is_load <= w_is_load;
                r_funct3  <= EX_funct3;
                r_alu     <= EX_ALUout;
                r_rd      <= ID_rd;
                r_req     <= 1'b1;
                r_we      <= w_is_store;
                r_addr    <= {EX_ALUout[ADDR_W-1:2], 2'b00};
                r_wdata   <= w_wdata;
                r_be      <= w_be;
            end else if ((r_state == StReq) && dmem_gnt) begin
                r_req <= 1'b0;
            end
        end
    end

`ifdef MEM_MISALIGN_TRAP_EN
    logic r_trap;
    always_ff @(posedge clk) begin
        if (rst) r_trap <= 1'b0;
        else     r_trap <= w_accept && w_misalign;
    end
    assign MEM_trap = r_trap;
`else
    assign MEM_trap = 1'b0;
`endif

    assign MEM_stall      = (r_state != StIdle);
    assign dmem_req       = r_req;
    assign dmem_we        = r_we;
    assign dmem_addr      = r_addr;
    assign dmem_wdata     = r_wdata;
    assign dmem_be        = r_be;
    assign MEM_valid      = r_valid;
    assign MEM_LMD        = r_lmd;
    assign MEM_ALUout     = r_alu_out;
    assign MEM_rd         = r_mem_rd;
    assign WB_LMD_flag    = r_lmd_flag;
    assign WB_ALUout_flag = r_alu_flag;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed vector table, reset/back-to-back sequences,
// and randomized transactions against an arithmetic reference model.
module tb_mem_stage;

    localparam logic [6:0] OP_LOAD  = 7'd3;
    localparam logic [6:0] OP_IMM   = 7'd19;
    localparam logic [6:0] OP_AUIPC = 7'd23;
    localparam logic [6:0] OP_STORE = 7'd35;
    localparam logic [6:0] OP_R     = 7'd51;
    localparam logic [6:0] OP_LUI   = 7'd55;
    localparam logic [6:0] OP_B     = 7'd99;
    localparam logic [6:0] OP_J     = 7'd111;

    logic        clk = 1'b0;
    logic        rst;
    logic        EX_valid;
    logic [6:0]  EX_opcode;
    logic [2:0]  EX_funct3;
    logic [31:0] EX_ALUout, EX_rs2;
    logic [4:0]  ID_rd;
    logic        MEM_stall, dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        MEM_valid;
    logic [31:0] MEM_LMD, MEM_ALUout;
    logic [4:0]  MEM_rd;
    logic        WB_LMD_flag, WB_ALUout_flag, MEM_trap;

    mem_stage #(.ADDR_W(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .EX_valid       (EX_valid),
        .EX_opcode      (EX_opcode),
        .EX_funct3      (EX_funct3),
        .EX_ALUout      (EX_ALUout),
        .EX_rs2         (EX_rs2),
        .ID_rd          (ID_rd),
        .MEM_stall      (MEM_stall),
        .dmem_req       (dmem_req),
        .dmem_we        (dmem_we),
        .dmem_addr      (dmem_addr),
        .dmem_wdata     (dmem_wdata),
        .dmem_be        (dmem_be),
        .dmem_gnt       (dmem_gnt),
        .dmem_rvalid    (dmem_rvalid),
        .dmem_rdata     (dmem_rdata),
        .MEM_valid      (MEM_valid),
        .MEM_LMD        (MEM_LMD),
        .MEM_ALUout     (MEM_ALUout),
        .MEM_rd         (MEM_rd),
        .WB_LMD_flag    (WB_LMD_flag),
        .WB_ALUout_flag (WB_ALUout_flag),
        .MEM_trap       (MEM_trap)
    );

    always #5 clk = ~clk;

    // Field order: inputs (op..rdata) then expected results (lat..trap).
    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [31:0] alu;
        logic [31:0] rs2;
        logic [4:0]  rd;
        int          gd;
        int          rvd;
        logic [31:0] rdata;
        int          lat;
        logic        req;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] lmd;
        logic        lflag;
        logic        aflag;
        logic        trap;
    } vec_t;

    int          total = 0;
    int          bad = 0;
    string       g_tag;
    logic [31:0] m_last_lmd;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s.%s got=0x%0h expected=0x%0h", g_tag, name, got, exp);
        end
    endtask

    function automatic vec_t model(input vec_t v);
        vec_t        o;
        int          a;
        bit          ld, st, alu, bsz, hsz, mis;
        logic [31:0] tmp;
        o   = v;
        a   = int'(v.alu[1:0]);
        ld  = (v.op == OP_LOAD);
        st  = (v.op == OP_STORE);
        alu = (v.op == OP_R) || (v.op == OP_IMM) || (v.op == OP_AUIPC) || (v.op == OP_LUI);
        bsz = (v.f3 == 3'd0) || (v.f3 == 3'd4);
        hsz = (v.f3 == 3'd1) || (v.f3 == 3'd5);
        mis = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
        mis = (ld || st) && ((hsz && (a % 2 == 1)) || (!bsz && !hsz && a != 0));
`endif
        o.trap  = mis;
        o.req   = (ld || st) && !mis;
        o.we    = st;
        o.addr  = v.alu & 32'hFFFF_FFFC;
        o.lflag = ld && !mis;
        o.aflag = alu;
        o.lat   = !o.req ? 1 : (st ? 2 + v.gd : 3 + v.gd + v.rvd);
        if (bsz) begin
            tmp     = 32'h1 << a;
            o.be    = tmp[3:0];
            o.wdata = {24'b0, v.rs2[7:0]} * 32'h0101_0101;
            o.lmd   = (v.rdata >> (8 * a)) & 32'hFF;
            if (v.f3 == 3'd0 && o.lmd >= 32'h80) o.lmd = o.lmd | 32'hFFFF_FF00;
        end else if (hsz) begin
            tmp     = 32'h3 << (2 * (a / 2));
            o.be    = tmp[3:0];
            o.wdata = {16'b0, v.rs2[15:0]} * 32'h0001_0001;
            o.lmd   = (v.rdata >> (16 * (a / 2))) & 32'hFFFF;
            if (v.f3 == 3'd1 && o.lmd >= 32'h8000) o.lmd = o.lmd | 32'hFFFF_0000;
        end else begin
            o.be    = 4'hF;
            o.wdata = v.rs2;
            o.lmd   = v.rdata;
        end
        return o;
    endfunction

    task automatic apply(input vec_t v, input bit noise);
        int          c, reqs, waits, stalls;
        bit          done, granted, seen_req;
        logic [31:0] a0, wd0;
        logic [3:0]  be0;
        logic        we0;
        c = 0; reqs = 0; waits = 0; stalls = 0;
        done = 0; granted = 0; seen_req = 0;
        a0 = '0; wd0 = '0; be0 = '0; we0 = 1'b0;
        @(negedge clk);
        check("prev_pulse_end", {31'b0, MEM_valid}, 32'd0);
        check("idle_stall", {31'b0, MEM_stall}, 32'd0);
        EX_valid = 1'b1; EX_opcode = v.op; EX_funct3 = v.f3;
        EX_ALUout = v.alu; EX_rs2 = v.rs2; ID_rd = v.rd;
        @(posedge clk);
        while (!done && c < 40) begin
            @(negedge clk);
            c++;
            EX_valid = 1'b0; EX_opcode = 7'($urandom); EX_funct3 = 3'($urandom);
            EX_ALUout = $urandom; EX_rs2 = $urandom; ID_rd = 5'($urandom);
            dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = $urandom;
            if (MEM_valid) begin
                done = 1;
            end else begin
                if (MEM_stall) stalls++;
                if (dmem_req) begin
                    if (!seen_req) begin
                        a0 = dmem_addr; be0 = dmem_be; wd0 = dmem_wdata; we0 = dmem_we;
                    end else begin
                        check("req_addr_stable", dmem_addr, a0);
                        check("req_be_stable", {28'b0, dmem_be}, {28'b0, be0});
                        check("req_wdata_stable", dmem_wdata, wd0);
                    end
                    seen_req = 1;
                    if (reqs == v.gd) begin
                        dmem_gnt = 1'b1;
                        granted  = 1;
                    end
                    reqs++;
                    if (noise) dmem_rvalid = 1'($urandom_range(0, 1));
                end else if (granted && v.op == OP_LOAD) begin
                    if (waits == v.rvd) begin
                        dmem_rvalid = 1'b1;
                        dmem_rdata  = v.rdata;
                    end
                    waits++;
                end
            end
        end
        check("latency", done ? c : 999, v.lat);
        if (!done) return;
        check("stall_cycles", stalls, v.lat - 1);
        check("stall_at_done", {31'b0, MEM_stall}, 32'd0);
        check("MEM_rd", {27'b0, MEM_rd}, {27'b0, v.rd});
        check("MEM_ALUout", MEM_ALUout, v.alu);
        check("WB_LMD_flag", {31'b0, WB_LMD_flag}, {31'b0, v.lflag});
        check("WB_ALUout_flag", {31'b0, WB_ALUout_flag}, {31'b0, v.aflag});
        check("MEM_trap", {31'b0, MEM_trap}, {31'b0, v.trap});
        check("req_seen", {31'b0, seen_req}, {31'b0, v.req});
        if (v.req && seen_req) begin
            check("dmem_addr", a0, v.addr);
            check("dmem_be", {28'b0, be0}, {28'b0, v.be});
            check("dmem_we", {31'b0, we0}, {31'b0, v.we});
            if (v.we) check("dmem_wdata", wd0, v.wdata);
        end
        if (v.lflag) m_last_lmd = v.lmd;
        check("MEM_LMD", MEM_LMD, m_last_lmd);
    endtask

    vec_t tbl[14];
    vec_t rv;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; EX_valid = 1'b0; EX_opcode = '0; EX_funct3 = '0; EX_ALUout = '0;
        EX_rs2 = '0; ID_rd = '0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
        m_last_lmd = '0;

        tbl[0]  = '{OP_R, 3'd0, 32'h1234, 32'h0, 5'd5, 0, 0, 32'h0,
                    1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0};
        tbl[1]  = '{OP_LOAD, 3'd0, 32'h103, 32'h0, 5'd7, 0, 0, 32'h80FF_0000,
                    3, 1'b1, 1'b0, 32'h100, 4'b1000, 32'h0, 32'hFFFF_FF80, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{OP_LOAD, 3'd5, 32'h102, 32'h0, 5'd8, 2, 0, 32'h8001_0000,
                    5, 1'b1, 1'b0, 32'h100, 4'b1100, 32'h0, 32'h0000_8001, 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{OP_STORE, 3'd0, 32'h21, 32'hAB, 5'd1, 0, 0, 32'h0,
                    2, 1'b1, 1'b1, 32'h20, 4'b0010, 32'hABAB_ABAB, 32'h0, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{OP_STORE, 3'd1, 32'h42, 32'h1234_5678, 5'd2, 1, 0, 32'h0,
                    3, 1'b1, 1'b1, 32'h40, 4'b1100, 32'h5678_5678, 32'h0, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{OP_STORE, 3'd2, 32'h80, 32'hDEAD_BEEF, 5'd3, 0, 0, 32'h0,
                    2, 1'b1, 1'b1, 32'h80, 4'hF, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{OP_LOAD, 3'd2, 32'h200, 32'h0, 5'd10, 1, 2, 32'hCAFE_F00D,
                    6, 1'b1, 1'b0, 32'h200, 4'hF, 32'h0, 32'hCAFE_F00D, 1'b1, 1'b0, 1'b0};
        tbl[7]  = '{OP_LOAD, 3'd1, 32'h0, 32'h0, 5'd11, 0, 1, 32'h0000_8765,
                    4, 1'b1, 1'b0, 32'h0, 4'b0011, 32'h0, 32'hFFFF_8765, 1'b1, 1'b0, 1'b0};
        tbl[8]  = '{OP_LOAD, 3'd4, 32'h1, 32'h0, 5'd12, 0, 0, 32'h0000_9A00,
                    3, 1'b1, 1'b0, 32'h0, 4'b0010, 32'h0, 32'h0000_009A, 1'b1, 1'b0, 1'b0};
        tbl[9]  = '{OP_B, 3'd0, 32'h40, 32'h0, 5'd0, 0, 0, 32'h0,
                    1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{OP_LUI, 3'd0, 32'hABCD_E000, 32'h0, 5'd13, 0, 0, 32'h0,
                    1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0};
        tbl[11] = '{OP_LOAD, 3'd3, 32'h10, 32'h0, 5'd14, 0, 0, 32'h89AB_CDEF,
                    3, 1'b1, 1'b0, 32'h10, 4'hF, 32'h0, 32'h89AB_CDEF, 1'b1, 1'b0, 1'b0};
`ifdef MEM_MISALIGN_TRAP_EN
        tbl[12] = '{OP_LOAD, 3'd2, 32'h6, 32'h0, 5'd15, 0, 0, 32'h0,
                    1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1};
        tbl[13] = '{OP_STORE, 3'd1, 32'h3, 32'h5555, 5'd16, 0, 0, 32'h0,
                    1, 1'b0, 1'b1, 32'h0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1};
`else
        tbl[12] = '{OP_LOAD, 3'd2, 32'h6, 32'h0, 5'd15, 0, 0, 32'h1122_3344,
                    3, 1'b1, 1'b0, 32'h4, 4'hF, 32'h0, 32'h1122_3344, 1'b1, 1'b0, 1'b0};
        tbl[13] = '{OP_LOAD, 3'd1, 32'h3, 32'h0, 5'd16, 0, 0, 32'hF00D_1234,
                    3, 1'b1, 1'b0, 32'h0, 4'b1100, 32'h0, 32'hFFFF_F00D, 1'b1, 1'b0, 1'b0};
`endif

        // Reset state
        g_tag = "reset";
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("MEM_stall", {31'b0, MEM_stall}, 32'd0);
        check("dmem_req", {31'b0, dmem_req}, 32'd0);
        check("dmem_we", {31'b0, dmem_we}, 32'd0);
        check("MEM_valid", {31'b0, MEM_valid}, 32'd0);
        check("MEM_trap", {31'b0, MEM_trap}, 32'd0);
        check("flags", {30'b0, WB_LMD_flag, WB_ALUout_flag}, 32'd0);
        check("MEM_LMD", MEM_LMD, 32'd0);
        check("MEM_ALUout", MEM_ALUout, 32'd0);
        check("dmem_addr", dmem_addr, 32'd0);
        check("dmem_wdata", dmem_wdata, 32'd0);
        check("be_rd", {23'b0, dmem_be, MEM_rd}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            g_tag = $sformatf("vec%0d", i);
            apply(tbl[i], 1'b0);
        end

        // Reset while waiting for rvalid; the late rvalid must be ignored.
        g_tag = "rst_in_wait";
        @(negedge clk);
        EX_valid = 1'b1; EX_opcode = OP_LOAD; EX_funct3 = 3'd2; EX_ALUout = 32'h300;
        ID_rd = 5'd9;
        @(negedge clk);
        EX_valid = 1'b0;
        check("req_in_req", {31'b0, dmem_req}, 32'd1);
        dmem_gnt = 1'b1;
        @(negedge clk);
        dmem_gnt = 1'b0;
        check("stall_in_wait", {31'b0, MEM_stall}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; m_last_lmd = '0;
        check("stall_after_rst", {31'b0, MEM_stall}, 32'd0);
        check("req_after_rst", {31'b0, dmem_req}, 32'd0);
        dmem_rvalid = 1'b1; dmem_rdata = 32'h7777_7777;
        @(negedge clk);
        dmem_rvalid = 1'b0;
        check("no_valid_late_rvalid", {31'b0, MEM_valid}, 32'd0);
        check("idle_late_rvalid", {31'b0, MEM_stall}, 32'd0);
        apply(tbl[0], 1'b0);

        // Reset while requesting a store; request drops and a stray gnt is ignored.
        g_tag = "rst_in_req";
        @(negedge clk);
        EX_valid = 1'b1; EX_opcode = OP_STORE; EX_funct3 = 3'd2; EX_ALUout = 32'h500;
        EX_rs2 = 32'h1; ID_rd = 5'd4;
        @(negedge clk);
        EX_valid = 1'b0;
        check("req_in_req", {31'b0, dmem_req}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("req_dropped", {31'b0, dmem_req}, 32'd0);
        check("stall_dropped", {31'b0, MEM_stall}, 32'd0);
        dmem_gnt = 1'b1;
        @(negedge clk);
        dmem_gnt = 1'b0;
        check("no_valid_stray_gnt", {31'b0, MEM_valid}, 32'd0);
        apply(tbl[10], 1'b0);

        // Back-to-back non-memory instructions, one per cycle.
        g_tag = "b2b";
        begin
            logic [31:0] vals[6];
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                check("stall", {31'b0, MEM_stall}, 32'd0);
                if (i > 0) begin
                    check("valid", {31'b0, MEM_valid}, 32'd1);
                    check("ALUout", MEM_ALUout, vals[i-1]);
                    check("rd", {27'b0, MEM_rd}, 32'(i - 1));
                end
                vals[i] = $urandom;
                EX_valid = 1'b1; EX_opcode = (i % 2 == 0) ? OP_IMM : OP_J;
                EX_ALUout = vals[i]; ID_rd = 5'(i);
            end
            @(negedge clk);
            EX_valid = 1'b0;
            check("valid_last", {31'b0, MEM_valid}, 32'd1);
            check("ALUout_last", MEM_ALUout, vals[5]);
            check("aflag_last", {31'b0, WB_ALUout_flag}, 32'd0);
        end

        // Randomized transactions against the reference model.
        for (int n = 0; n < 150; n++) begin
            g_tag = $sformatf("rand%0d", n);
            case ($urandom_range(0, 7))
                0, 1, 2: rv.op = OP_LOAD;
                3, 4:    rv.op = OP_STORE;
                5:       rv.op = OP_R;
                6:       rv.op = ($urandom_range(0, 1) != 0) ? OP_AUIPC : OP_LUI;
                default: rv.op = ($urandom_range(0, 1) != 0) ? OP_B : OP_J;
            endcase
            rv.f3    = (rv.op == OP_STORE) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
            rv.alu   = $urandom;
            rv.rs2   = $urandom;
            rv.rd    = 5'($urandom);
            rv.gd    = $urandom_range(0, 3);
            rv.rvd   = $urandom_range(0, 3);
            rv.rdata = $urandom;
            apply(model(rv), 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
